seq_pattern_gen: RTL and testbench
==================================

# seq_pattern_gen

Serial pattern generator: the transmit-side counterpart of the team's consecutive-equal-bit sequence detector. Loads a pattern of up to MAX_LEN bits, shifts it out MSB-first one bit per clock, and optionally repeats it. Alongside each bit it drives the detector's predicted response, so a bench can check the detector against a self-consistent reference. The block drives the detector's `inp` directly in the verification top.

## Interface
- MAX_LEN, 16, maximum pattern length in bits (≥2)
- REP_W, 4, width of the repeat count
- LEN_W, $clog2(MAX_LEN)+1, width of the length field (derived; do not override)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  load request
- load_ready  out  1  high exactly when the FSM is in IDLE
- load_pattern  in  MAX_LEN  pattern; only bits [load_len-1:0] are used
- load_len  in  LEN_W  pattern length; legal range 1..MAX_LEN
- load_repeat  in  REP_W  extra repetitions (0 = emit once)
- abort  in  1  stop transmission
- ser_out  out  1  serial bit; 0 whenever ser_valid=0
- ser_valid  out  1  ser_out carries a pattern bit this cycle
- exp_match  out  1  emitted bit equals the previous emitted bit of the same stream
- done  out  1  one-cycle pulse on natural completion
- err  out  1  one-cycle pulse on a rejected load

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - load_ready=1.
  - Handshake: load_valid && load_len in 1..MAX_LEN → capture pattern, len and repeat; clear bit history; go to RUN.
  - load_valid with load_len=0 or load_len>MAX_LEN → err=1 next cycle; stay in IDLE.
  - abort is ignored.
- **RUN**
  - Each cycle, ser_valid=1 and ser_out = pattern[idx]. idx starts at len-1 and decrements.
  - At idx=0: if the remaining repeat count >0, decrement it and reload idx=len-1 with no gap cycle. Otherwise go to DONE.
  - Total ser_valid cycles = len × (repeat+1).
- **DONE**
  - done=1 and load_ready=0 for one cycle, then return to IDLE.
- **abort in RUN**
  - Next cycle: IDLE, ser_valid=0, ser_out=0, exp_match=0. No done pulse.
  - The abort cycle's own bit is still emitted.
- **exp_match**
  - Equals ser_valid && (ser_out == previous emitted bit).
  - History is cleared on every accepted load, so the first bit of a stream is always 0.
  - History carries across repeat boundaries, since repeats form one continuous stream.
- **Width rules**
  - idx is LEN_W bits; repeat counter is REP_W bits.
  - No wrap-around is possible, because idx is reloaded before it underflows.
- **rst**
  - Overrides everything, including mid-RUN.
  - Next edge: IDLE with all registers cleared.

## Timing
- Reset values: ser_out=0, ser_valid=0, exp_match=0, done=0, err=0. load_ready=1 after the reset edge (IDLE).
- ser_out, ser_valid, exp_match, done and err are registered. load_ready is decoded from state.
- Latency: load accepted at edge N → first bit valid in the cycle after edge N.
- The last bit is followed by exactly one DONE cycle, then IDLE. The earliest next load is accepted in that IDLE cycle, so the minimum gap between streams is 2 cycles.
- Detector alignment: detector `outp` for the bit driven in cycle t appears in cycle t+2 (state register, then output register). The bench compares detector `outp` at t+2 against exp_match at t.
- Detector reset behaviour is intentionally not modelled: at a stream start its history may be stale, so the bench pulses the detector's reset before each stream.

## Structure
- Shared package `seq_gen_pkg`:
  - state enum {IDLE, RUN, DONE}
  - LEN_W derivation function
  - default MAX_LEN/REP_W constants
- One sub-module, `pattern_shifter`:
  - holds pattern, idx and repeat counter
  - provides load, step and last outputs
- Top handles the FSM, handshake, validity checks and exp_match history.

## Test plan
- Pattern 4'b1100, len 4, rep 0 → ser_out 1,1,0,0; exp_match 0,1,0,1; done on the 5th cycle after acceptance; detector outp 0,1,0,1 offset by 2.
- Pattern 3'b101, len 3, rep 1 → ser_out 1,0,1,1,0,1; exp_match 0,0,0,1,0,0; 6 valid cycles, then a single done pulse.
- load_len=0, then load_len=17 (MAX_LEN=16) → err pulse each time; ser_valid stays 0; load_ready stays 1.
- Pattern 16'hFFFF, len 16, abort asserted on the 5th valid cycle → 5 bits emitted, then ser_valid=0 and IDLE; no done pulse.
- rst asserted on the 3rd valid cycle → next cycle: all outputs 0, load_ready=1; a subsequent load behaves as after power-up.
- load_valid held high with back-to-back loads of 2'b11 → second stream starts 2 cycles after the first ends; first exp_match of each stream is 0.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared types and constants for the serial pattern generator.
//   state_t      - generator FSM states
//   calc_len_w   - width of a length field able to hold 0..max_len
//   DEF_MAX_LEN  - default maximum pattern length
//   DEF_REP_W    - default repeat-counter width
package seq_gen_pkg;

  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_REP_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One extra bit beyond the index width so MAX_LEN itself is representable
  // and out-of-range lengths (e.g. MAX_LEN+1) can be detected and rejected.
  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/pattern_shifter.sv
// pattern_shifter: holds the loaded pattern, the current bit index and the
// remaining repeat count, and presents the bit that the next step will emit.
//   clk, rst     - clock, synchronous active-high reset
//   i_load       - capture i_pattern/i_len/i_repeat, idx := len-1
//   i_step       - advance to the next bit (wraps to len-1 while repeats remain)
//   i_pattern    - pattern, bits [i_len-1:0] used
//   i_len        - pattern length (caller guarantees 1..MAX_LEN on load)
//   i_repeat     - extra repetitions
//   o_first_bit  - i_pattern[i_len-1], the first bit of a stream being loaded
//   o_next_bit   - bit emitted after the next step
//   o_last       - current bit is the final bit of the whole stream
module pattern_shifter
  import seq_gen_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int REP_W   = DEF_REP_W,
  parameter int LEN_W   = calc_len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [MAX_LEN-1:0] i_pattern,
  input  logic [LEN_W-1:0]   i_len,
  input  logic [REP_W-1:0]   i_repeat,
  output logic               o_first_bit,
  output logic               o_next_bit,
  output logic               o_last
);

  localparam int IDX_W = $clog2(MAX_LEN);

  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_idx;
  logic [REP_W-1:0]   r_rep;

  logic [LEN_W-1:0]   w_first_idx;
  logic [LEN_W-1:0]   w_next_idx;
  logic               w_wrap;

  assign w_first_idx = i_len - LEN_W'(1);
  assign w_wrap      = (r_idx == '0);
  // idx is reloaded at zero rather than decremented, so it never underflows.
  assign w_next_idx  = w_wrap ? (r_len - LEN_W'(1)) : (r_idx - LEN_W'(1));

  assign o_first_bit = i_pattern[w_first_idx[IDX_W-1:0]];
  assign o_next_bit  = r_pattern[w_next_idx[IDX_W-1:0]];
  assign o_last      = w_wrap && (r_rep == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_rep     <= '0;
    end else if (i_load) begin
      r_pattern <= i_pattern;
      r_len     <= i_len;
      r_idx     <= w_first_idx;
      r_rep     <= i_repeat;
    end else if (i_step) begin
      r_idx <= w_next_idx;
      if (w_wrap) r_rep <= r_rep - REP_W'(1);
    end
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: loads a pattern and shifts it out MSB-first, one bit per
// clock, optionally repeated, together with the predicted response of a
// consecutive-equal-bit detector (exp_match).
//   clk, rst      - clock, synchronous active-high reset
//   load_valid    - load request (accepted only in IDLE)
//   load_ready    - high exactly in IDLE
//   load_pattern  - pattern, bits [load_len-1:0] used
//   load_len      - length, legal 1..MAX_LEN; otherwise err pulses
//   load_repeat   - extra repetitions (0 = emit once)
//   abort         - stop an ongoing stream (no done pulse)
//   ser_out       - serial bit, 0 when ser_valid=0
//   ser_valid     - ser_out carries a pattern bit
//   exp_match     - emitted bit equals the previous bit of the same stream
//   done          - one-cycle pulse on natural completion
//   err           - one-cycle pulse on a rejected load
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int REP_W   = DEF_REP_W,
  parameter int LEN_W   = calc_len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [MAX_LEN-1:0] load_pattern,
  input  logic [LEN_W-1:0]   load_len,
  input  logic [REP_W-1:0]   load_repeat,
  input  logic               abort,
  output logic               ser_out,
  output logic               ser_valid,
  output logic               exp_match,
  output logic               done,
  output logic               err
);

  state_t r_state, w_state_nxt;

  logic r_ser_out, r_ser_valid, r_exp_match, r_done, r_err;
  logic w_ser_out_nxt, w_ser_valid_nxt, w_exp_match_nxt, w_done_nxt, w_err_nxt;
  logic w_load, w_step, w_len_ok;
  logic w_first_bit, w_next_bit, w_last;

  assign w_len_ok = (load_len != '0) && (load_len <= LEN_W'(MAX_LEN));

  pattern_shifter #(
    .MAX_LEN (MAX_LEN),
    .REP_W   (REP_W),
    .LEN_W   (LEN_W)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_pattern   (load_pattern),
    .i_len       (load_len),
    .i_repeat    (load_repeat),
    .o_first_bit (w_first_bit),
    .o_next_bit  (w_next_bit),
    .o_last      (w_last)
  );

  // All serial outputs are registered, so they are computed here for the
  // cycle after the coming edge, alongside the next state.
  always_comb begin
    w_state_nxt     = r_state;
    w_load          = 1'b0;
    w_step          = 1'b0;
    w_ser_out_nxt   = 1'b0;
    w_ser_valid_nxt = 1'b0;
    w_exp_match_nxt = 1'b0;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (load_valid) begin
          if (w_len_ok) begin
            w_load          = 1'b1;
            w_state_nxt     = RUN;
            w_ser_valid_nxt = 1'b1;
            w_ser_out_nxt   = w_first_bit;
            // History cleared on load: first bit of a stream never matches.
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_last) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_step          = 1'b1;
          w_ser_valid_nxt = 1'b1;
          w_ser_out_nxt   = w_next_bit;
          // r_ser_out is the bit on the wire now, i.e. the previous bit of
          // the next cycle; this also carries history across repeats.
          w_exp_match_nxt = (w_next_bit == r_ser_out);
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_exp_match <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ser_out   <= w_ser_out_nxt;
      r_ser_valid <= w_ser_valid_nxt;
      r_exp_match <= w_exp_match_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign load_ready = (r_state == IDLE);
  assign ser_out    = r_ser_out;
  assign ser_valid  = r_ser_valid;
  assign exp_match  = r_exp_match;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_seq_pattern_gen.sv
module tb_seq_pattern_gen;

  localparam int MAX_LEN = 16;
  localparam int REP_W   = 4;
  localparam int LEN_W   = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               load_valid;
  logic               load_ready;
  logic [MAX_LEN-1:0] load_pattern;
  logic [LEN_W-1:0]   load_len;
  logic [REP_W-1:0]   load_repeat;
  logic               abort;
  logic               ser_out, ser_valid, exp_match, done, err;

  always #5 clk = ~clk;

  seq_pattern_gen #(.MAX_LEN(MAX_LEN), .REP_W(REP_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_pattern (load_pattern),
    .load_len     (load_len),
    .load_repeat  (load_repeat),
    .abort        (abort),
    .ser_out      (ser_out),
    .ser_valid    (ser_valid),
    .exp_match    (exp_match),
    .done         (done),
    .err          (err)
  );

  typedef struct packed {
    logic v, o, m, d, e, r;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s t=%0t got %0h want %0h", tag, $time, act, exp_v);
    end
  endtask

  // Reference: a stream is expanded to its full bit sequence on acceptance;
  // each cycle consumes one bit, then one done cycle, then idle.
  logic m_q[$];
  logic m_run  = 1'b0;
  logic m_done = 1'b0;
  logic m_cur  = 1'b0;

  task automatic model_step();
    exp_t e;
    logic b;
    e = '0;
    if (rst) begin
      m_q.delete(); m_run = 1'b0; m_done = 1'b0; e.r = 1'b1;
    end else if (m_done) begin
      m_done = 1'b0; e.r = 1'b1;
    end else if (m_run) begin
      if (abort) begin
        m_q.delete(); m_run = 1'b0; e.r = 1'b1;
      end else if (m_q.size() == 0) begin
        m_run = 1'b0; m_done = 1'b1; e.d = 1'b1;
      end else begin
        b = m_q.pop_front();
        e.v = 1'b1; e.o = b; e.m = (b == m_cur); m_cur = b;
      end
    end else begin
      e.r = 1'b1;
      if (load_valid) begin
        if (load_len >= 1 && load_len <= MAX_LEN) begin
          m_q.delete();
          for (int r = 0; r <= int'(load_repeat); r++)
            for (int i = int'(load_len) - 1; i >= 0; i--)
              m_q.push_back(load_pattern[i]);
          b = m_q.pop_front();
          e.v = 1'b1; e.o = b; e.m = 1'b0; m_cur = b;
          m_run = 1'b1; e.r = 1'b0;
        end else begin
          e.e = 1'b1;
        end
      end
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("ser_valid",  32'(ser_valid),  32'(x.v));
      chk("ser_out",    32'(ser_out),    32'(x.o));
      chk("exp_match",  32'(exp_match),  32'(x.m));
      chk("done",       32'(done),       32'(x.d));
      chk("err",        32'(err),        32'(x.e));
      chk("load_ready", 32'(load_ready), 32'(x.r));
    end
  end

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                      input logic [REP_W-1:0] r);
    load_valid = 1'b1; load_pattern = p; load_len = l; load_repeat = r;
    cyc();
    load_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_pattern = '0; load_len = '0;
    load_repeat = '0; abort = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(2);

    load(16'h000C, 5'd4, 4'd0);          // 1100
    idle(7);
    load(16'h0005, 5'd3, 4'd1);          // 101 twice
    idle(9);

    load(16'hFFFF, 5'd0, 4'd0);          // rejected
    idle(2);
    load(16'hFFFF, 5'd17, 4'd0);         // rejected
    idle(2);

    load(16'hFFFF, 5'd16, 4'd0);
    idle(4);
    abort = 1'b1; cyc(); abort = 1'b0;   // 5th valid cycle
    idle(3);

    load(16'h000A, 5'd4, 4'd2);
    idle(2);
    rst = 1'b1; cyc(); rst = 1'b0;       // 3rd valid cycle
    idle(2);
    load(16'h000C, 5'd4, 4'd0);
    idle(7);

    // Back-to-back with load_valid held high
    load_valid = 1'b1; load_pattern = 16'h0003; load_len = 5'd2; load_repeat = '0;
    idle(12);
    load_valid = 1'b0;
    idle(3);

    // Boundaries: len 1 with repeats, full length, abort in IDLE ignored
    load(16'h0001, 5'd1, 4'd2);
    idle(5);
    load(16'hA5C3, 5'd16, 4'd0);
    idle(19);
    abort = 1'b1; idle(2); abort = 1'b0;

    for (int k = 0; k < 5; k++) begin
      logic [LEN_W-1:0] l;
      logic [REP_W-1:0] r;
      l = LEN_W'($urandom_range(1, MAX_LEN));
      r = REP_W'($urandom_range(0, 3));
      load(MAX_LEN'($urandom), l, r);
      idle(int'(l) * (int'(r) + 1) + 3);
    end

    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
